// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Integer register file with a pending-bit scoreboard. It has two write
// ports: port 0 takes short-latency results and port 1 takes long-latency
// results such as loads. An issue port marks a destination register pending
// until its port-1 writeback arrives. Register 0 is hardwired to zero.
//
// Parameters
//   XLEN    data width in bits
//   NREG    register count (power of two, >= 2)
//   NRD     number of read ports
//   BYPASS  1 = same-cycle write-to-read forwarding, 0 = none
//
// Ports
//   clk            single clock, all state updates on posedge
//   rst_n          synchronous active-low reset
//   ra     [NRD]   read addresses
//   rd     [NRD]   read data (combinational)
//   rd_rdy [NRD]   1 when the read value is final (register not pending)
//   we0/wa0/wd0    write port 0 (short-latency results)
//   we1/wa1/wd1    write port 1 (long-latency results, clears pending bit)
//   iss_v/iss_a    issue, marks register iss_a pending
//   busy   [NREG]  registered pending bit vector
// ---------------------------------------------------------------------------
module reg_file_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NRD-1:0][AW-1:0]    ra,
   output logic [NRD-1:0][XLEN-1:0]  rd,
   output logic [NRD-1:0]            rd_rdy,
   input  logic                      we0,
   input  logic [AW-1:0]             wa0,
   input  logic [XLEN-1:0]           wd0,
   input  logic                      we1,
   input  logic [AW-1:0]             wa1,
   input  logic [XLEN-1:0]           wd1,
   input  logic                      iss_v,
   input  logic [AW-1:0]             iss_a,
   output logic [NREG-1:0]           busy
);

   localparam bit BypassEn = (BYPASS != 0);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   logic wr0Valid;
   logic wr1Valid;
   logic issValid;

   // Writes and issues that target register 0 are silently dropped.
   assign wr0Valid = we0   && (wa0   != '0);
   assign wr1Valid = we1   && (wa1   != '0);
   assign issValid = iss_v && (iss_a != '0);

   // Next register contents. Port 1 is applied after port 0 so that a
   // same-address collision stores the long-latency result.
   always_comb begin
      regs_d = regs_q;
      if (wr0Valid) begin
         regs_d[wa0] = wd0;
      end
      if (wr1Valid) begin
         regs_d[wa1] = wd1;
      end
      regs_d[0] = '0;
   end

   // Next pending vector. A writeback clears its bit first and an issue
   // sets afterwards, so a same-cycle issue to that register leaves it
   // pending. Setting an already set bit is a no-op, so there is no counting.
   // Port 0 never touches the scoreboard.
   always_comb begin
      busy_d = busy_q;
      if (wr1Valid) begin
         busy_d[wa1] = 1'b0;
      end
      if (issValid) begin
         busy_d[iss_a] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers. Reset wins over any write or issue in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

   // Read ports. With forwarding enabled, a write landing this cycle is
   // visible immediately, and port 1 takes priority over port 0 to match the
   // storage order. A register under a port-1 writeback is reported ready
   // because the forwarded value is the final one.
   always_comb begin
      rd     = '0;
      rd_rdy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (ra[i] == '0) begin
            rd[i]     = '0;
            rd_rdy[i] = 1'b1;
         end else begin
            rd[i]     = regs_q[ra[i]];
            rd_rdy[i] = !busy_q[ra[i]];
            if (BypassEn) begin
               if (we0 && (wa0 == ra[i])) begin
                  rd[i] = wd0;
               end
               if (we1 && (wa1 == ra[i])) begin
                  rd[i]     = wd1;
                  rd_rdy[i] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed bench for reg_file_sb. One instance has forwarding enabled (A)
// and one has it disabled (B). Both share the same stimulus, so the
// difference between forwarded and stored values can be seen side by side.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic                     clk;
   logic                     rst_n;
   logic [NRD-1:0][AW-1:0]   ra;
   logic [NRD-1:0][XLEN-1:0] rdA;
   logic [NRD-1:0][XLEN-1:0] rdB;
   logic [NRD-1:0]           rdyA;
   logic [NRD-1:0]           rdyB;
   logic                     we0;
   logic [AW-1:0]            wa0;
   logic [XLEN-1:0]          wd0;
   logic                     we1;
   logic [AW-1:0]            wa1;
   logic [XLEN-1:0]          wd1;
   logic                     issV;
   logic [AW-1:0]            issA;
   logic [NREG-1:0]          busyA;
   logic [NREG-1:0]          busyB;

   int checkCount;
   int failCount;

   reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dutA (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rdA), .rd_rdy(rdyA),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .iss_v(issV), .iss_a(issA), .busy(busyA)
   );

   reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dutB (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rdB), .rd_rdy(rdyB),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .iss_v(issV), .iss_a(issA), .busy(busyB)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives every write and issue input at once.
   task automatic applyStimulus(input logic w0, input logic [AW-1:0] a0,
                                input logic [XLEN-1:0] d0, input logic w1,
                                input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                                input logic iv, input logic [AW-1:0] ia);
      we0  = w0;
      wa0  = a0;
      wd0  = d0;
      we1  = w1;
      wa1  = a1;
      wd1  = d1;
      issV = iv;
      issA = ia;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   // Advances one clock and settles just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_n      = 1'b0;
      ra         = '0;

      // The reset-cycle write and issue must be discarded.
      applyStimulus(1'b1, 5'd5, 32'h1234, 1'b1, 5'd6, 32'h5678, 1'b1, 5'd6);
      tick();
      tick();
      rst_n = 1'b1;
      idle();

      // Reset state
      ra[0] = 5'd0;
      ra[1] = 5'd5;
      #1;
      checkOutput("rst_rd0",   rdA[0], 0);
      checkOutput("rst_rd1",   rdA[1], 0);
      checkOutput("rst_rdy",   rdyA,   2'b11);
      checkOutput("rst_busyA", busyA,  0);
      checkOutput("rst_busyB", busyB,  0);
      ra[0] = 5'd6;
      #1;
      checkOutput("rst_reg6",  rdB[0], 0);

      // Port 0 write with a same-cycle read
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
      ra[0] = 5'd5;
      #1;
      checkOutput("byp_w0_A",  rdA[0], 32'hDEADBEEF);
      checkOutput("byp_w0_B",  rdB[0], 0);
      tick();
      idle();
      #1;
      checkOutput("st_w0_B",   rdB[0], 32'hDEADBEEF);
      checkOutput("st_w0_A",   rdA[0], 32'hDEADBEEF);

      // Both ports writing the same register: port 1 wins
      applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, '0);
      ra[0] = 5'd7;
      ra[1] = 5'd7;
      #1;
      checkOutput("coll_byp_A", rdA[0], 32'h22);
      tick();
      idle();
      #1;
      checkOutput("coll_A",    rdA[0], 32'h22);
      checkOutput("coll_B",    rdB[1], 32'h22);
      checkOutput("coll_busy", busyA,  0);

      // Issue then port-1 writeback
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
      tick();
      idle();
      ra[0] = 5'd3;
      ra[1] = 5'd0;
      #1;
      checkOutput("iss_busy",  busyA,  32'h8);
      checkOutput("iss_rdyA",  rdyA,   2'b10);
      checkOutput("iss_rdyB",  rdyB,   2'b10);
      tick();
      checkOutput("iss_hold",  busyA,  32'h8);
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'h55, 1'b0, '0);
      #1;
      checkOutput("wb_rdA",    rdA[0], 32'h55);
      checkOutput("wb_rdyA",   rdyA,   2'b11);
      checkOutput("wb_rdB",    rdB[0], 0);
      checkOutput("wb_rdyB",   rdyB,   2'b10);
      tick();
      idle();
      #1;
      checkOutput("wb_busyA",  busyA,  0);
      checkOutput("wb_busyB",  busyB,  0);
      checkOutput("wb_stB",    rdB[0], 32'h55);

      // A port-0 write to a pending register leaves it pending
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
      tick();
      applyStimulus(1'b1, 5'd3, 32'h66, 1'b0, '0, '0, 1'b0, '0);
      #1;
      checkOutput("w0busy_rdy", rdyA[0], 1'b0);
      tick();
      idle();
      #1;
      checkOutput("w0busy_busy", busyA, 32'h8);
      checkOutput("w0busy_data", rdB[0], 32'h66);

      // Issue and port-1 writeback to the same register in one cycle
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'h99, 1'b1, 5'd4);
      tick();
      idle();
      ra[1] = 5'd4;
      #1;
      checkOutput("isswb_busy", busyA,  32'h18);
      checkOutput("isswb_data", rdB[1], 32'h99);

      // A repeat issue does not count, so a single writeback clears it
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4);
      tick();
      checkOutput("reiss_busy", busyA,  32'h18);
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'h9A, 1'b0, '0);
      tick();
      idle();
      #1;
      checkOutput("reiss_clr",  busyA,  32'h8);
      checkOutput("reiss_data", rdB[1], 32'h9A);

      // Register 0 ignores writes and issues on every port
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 5'd0);
      ra[0] = 5'd0;
      ra[1] = 5'd0;
      #1;
      checkOutput("r0_byp",    rdA[0], 0);
      checkOutput("r0_rdy",    rdyA,   2'b11);
      tick();
      idle();
      #1;
      checkOutput("r0_rd",     rdA[1], 0);
      checkOutput("r0_busy",   busyA,  32'h8);

      // Reset mid-operation clears pending bits and discards same-cycle traffic
      rst_n = 1'b0;
      applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h78, 1'b1, 5'd9);
      tick();
      rst_n = 1'b1;
      idle();
      ra[0] = 5'd3;
      ra[1] = 5'd7;
      #1;
      checkOutput("mrst_busyA", busyA, 0);
      checkOutput("mrst_busyB", busyB, 0);
      checkOutput("mrst_rd3",   rdA[0], 0);
      checkOutput("mrst_rd7",   rdA[1], 0);
      checkOutput("mrst_rdy",   rdyA,   2'b11);

      // A late writeback after reset stores data and leaves busy clear
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'hAB, 1'b0, '0);
      tick();
      idle();
      #1;
      checkOutput("late_busy", busyA,  0);
      checkOutput("late_data", rdB[0], 32'hAB);
      checkOutput("late_rdy",  rdyB,   2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
